aes_core: RTL and testbench
===========================

Name: aes_core

Overview:
- Iterative AES-128 encryption core (FIPS-197): one 128-bit plaintext block and one 128-bit cipher key in, one 128-bit ciphertext block out.
- Executes one round per clock and expands round keys on the fly; no key RAM.
- Start of operation is the release of reset. The core encrypts one block per reset pulse, then holds the result with `d_vld` high until the next reset.

Parameters:
- None. Fixed at AES-128: 10 rounds, 128-bit key.

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `d_in` input 128: plaintext block. Bits [127:120] are FIPS byte 0; bytes map to the state column-major.
- `key_in` input 128: cipher key, same byte ordering as `d_in`.
- `d_out` output 128: ciphertext block, same byte ordering; registered.
- `d_vld` output 1: ciphertext valid; registered, level signal.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset (`rst` = 0), applied asynchronously:
  - `d_out` = 0, `d_vld` = 0, round counter = 0, FSM = LOAD.
  - State and round-key registers cleared.
- FSM states are LOAD, ROUND, DONE.
- LOAD: first rising edge with `rst` = 1.
  - state <= `d_in` XOR `key_in` (initial AddRoundKey).
  - roundkey <= `key_in`, round <= 1, go to ROUND.
  - `d_in` and `key_in` are sampled only on this edge; later changes are ignored until the next reset.
- ROUND: one edge per round, round = 1..10.
  - Next round key from the current round key:
    - w0' = w0 XOR SubWord(RotWord(w3)) XOR Rcon[round]
    - w1' = w1 XOR w0', w2' = w2 XOR w1', w3' = w3 XOR w2'
    - w0 = bits [127:96].
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36, placed in the MSB byte of the word.
  - Rounds 1–9: state <= MixColumns(ShiftRows(SubBytes(state))) XOR next round key.
  - Round 10: MixColumns is skipped. The result is written directly into `d_out`, `d_vld` <= 1, go to DONE.
- DONE: `d_out` and `d_vld` hold unchanged indefinitely. Inputs are ignored. Only reset leaves DONE.
- Latency:
  - Edge 1 after reset release = LOAD; edges 2..11 = rounds 1..10.
  - `d_vld` rises on the 11th rising edge after `rst` goes high.
- `d_out` is 0 whenever `d_vld` = 0; it is never driven with an intermediate state.
- SubBytes uses the standard AES S-box, combinational (16 instances for data, 4 for key expansion), in a shared sub-module or function.
- MixColumns uses GF(2^8) with polynomial x^8+x^4+x^3+x+1. xtime(b) = (b<<1) XOR (1B if b[7]).
- Reset mid-operation (any state): abort immediately. Outputs go to 0 and the core restarts with LOAD after release; no partial result is visible.
- Reset asserted while in DONE: `d_vld` and `d_out` drop to 0 asynchronously, without waiting for a clock edge.
- Back-to-back blocks: pulse `rst` low for at least one clock period, present new `d_in`/`key_in` before the first rising edge after release.

Test Plan:
- Reset values: hold `rst` = 0 across several clocks.
  - Required: `d_out` = 0, `d_vld` = 0.
  - Assert `rst` asynchronously between edges; outputs clear without a clock.
- FIPS-197 C.1: `key_in` = 000102030405060708090a0b0c0d0e0f, `d_in` = 00112233445566778899aabbccddeeff, release reset.
  - Required: `d_vld` rises on the 11th edge.
  - `d_out` = 69c4e0d86a7b0430d8cdb78070b4c55a, held stable for ≥20 further cycles.
- FIPS-197 App. B: `key_in` = 2b7e151628aed2a6abf7158809cf4f3c, `d_in` = 3243f6a8885a308d313198a2e0370734.
  - Required: `d_out` = 3925841d02dc09fbdc118597196a0b32.
- All-zero key and plaintext.
  - Required: `d_out` = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Input stability: start the C.1 vector, then randomize `d_in`/`key_in` every cycle after the LOAD edge.
  - Required: result is still 69c4e0d86a7b0430d8cdb78070b4c55a.
- Abort and back-to-back:
  - Assert reset during round 5 of App. B. Required: `d_vld` stays 0.
  - Then run C.1, pulse reset, then run zero vector. Required: each result is correct with 11-edge latency, and `d_vld` drops between blocks.

Source files
------------

// File: rtl/aes_core.sv
// Iterative AES-128 encryptor: one block per reset pulse, one round per clock, round keys expanded on the fly.
// Latency 11 edges after reset release; result then holds with d_vld high until reset (no backpressure).
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] d_in,
  input  logic [127:0] key_in,
  output logic [127:0] d_out,
  output logic         d_vld
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {LOAD, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state, rkey, key_nxt, sb_sr, mixed;
  logic [3:0]   round;
  logic         load_en, round_en, last;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(r), 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign key_nxt = expand(rkey, round);
  assign sb_sr   = sub_shift(state);
  assign mixed   = mix_cols(sb_sr);
  assign last    = (round == 4'd10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= LOAD;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      LOAD:    fsm_nxt = ROUND;
      ROUND:   fsm_nxt = last ? DONE : ROUND;
      DONE:    fsm_nxt = DONE;
      default: fsm_nxt = LOAD;
    endcase
  end

  always_comb begin
    load_en  = (fsm == LOAD);
    round_en = (fsm == ROUND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      rkey  <= '0;
      round <= '0;
      d_out <= '0;
      d_vld <= 1'b0;
    end else if (load_en) begin
      state <= d_in ^ key_in;
      rkey  <= key_in;
      round <= 4'd1;
    end else if (round_en) begin
      rkey  <= key_nxt;
      round <= round + 4'd1;
      if (last) begin
        d_out <= sb_sr ^ key_nxt;
        d_vld <= 1'b1;
      end else begin
        state <= mixed ^ key_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_core.sv
// Directed bench for aes_core: FIPS-197 vectors, latency, hold, input stability, async reset and abort.
module tb_aes_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] d_in, key_in, d_out;
  logic         d_vld;
  int           checks = 0;
  int           errors = 0;

  aes_core dut (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .key_in (key_in),
    .d_out  (d_out),
    .d_vld  (d_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Holds reset across one full clock with the new block presented, releases it on a falling edge.
  task automatic start(input logic [127:0] k, input logic [127:0] p);
    rst    = 1'b0;
    d_in   = p;
    key_in = k;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Counts rising edges after release until d_vld; flags any nonzero d_out seen before that.
  task automatic wait_done(input bit scramble, output int lat);
    bit leak;
    leak = 1'b0;
    lat  = 0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        d_in   = rnd128();
        key_in = rnd128();
      end
      if (d_vld === 1'b1) lat = e;
      else if (d_out !== '0) leak = 1'b1;
    end
    chk("no_early_dout", 128'(leak), 128'd0);
  endtask

  initial begin
    int           lat;
    logic [127:0] held;
    bit           moved;

    vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT};
    vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT};
    vecs[2] = '{key: '0,     pt: '0,    ct: Z_CT};

    rst = 1'b0; d_in = rnd128(); key_in = rnd128();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_dvld", 128'(d_vld), 128'd0);
    chk("reset_dout", d_out, '0);

    for (int i = 0; i < 3; i++) begin
      start(vecs[i].key, vecs[i].pt);
      wait_done(1'b0, lat);
      chk($sformatf("latency_v%0d", i), 128'(lat), 128'd11);
      chk($sformatf("dout_v%0d", i), d_out, vecs[i].ct);
      held  = d_out;
      moved = 1'b0;
      for (int c = 0; c < 20; c++) begin
        d_in   = rnd128();
        key_in = rnd128();
        @(posedge clk);
        #1;
        if (d_out !== held || d_vld !== 1'b1) moved = 1'b1;
      end
      chk($sformatf("hold_v%0d", i), 128'(moved), 128'd0);
      // Mid-cycle reset must clear outputs before any further clock edge.
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk($sformatf("async_clr_dvld_v%0d", i), 128'(d_vld), 128'd0);
      chk($sformatf("async_clr_dout_v%0d", i), d_out, '0);
    end

    start(C1_KEY, C1_PT);
    wait_done(1'b1, lat);
    chk("scramble_latency", 128'(lat), 128'd11);
    chk("scramble_dout", d_out, C1_CT);

    // Abort App. B while round 5 is in flight.
    start(B_KEY, B_PT);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_dvld", 128'(d_vld), 128'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_dvld_later", 128'(d_vld), 128'd0);
    chk("abort_dout_later", d_out, '0);

    start(C1_KEY, C1_PT);
    wait_done(1'b0, lat);
    chk("b2b_c1_latency", 128'(lat), 128'd11);
    chk("b2b_c1_dout", d_out, C1_CT);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("b2b_drop_dvld", 128'(d_vld), 128'd0);
    start('0, '0);
    wait_done(1'b0, lat);
    chk("b2b_zero_latency", 128'(lat), 128'd11);
    chk("b2b_zero_dout", d_out, Z_CT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
